// File: rtl/tiny_eth_pkg.sv
// Shared types and constants for the tiny_eth transmit path.
// CRC constants are consumed only when TINY_ETH_TX_FCS_EN is defined.
package tiny_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_DROP,
    ST_IFG
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE     = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE          = 4'hD;
  localparam logic [31:0] CRC32_POLY          = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFF_FFFF;
  // Magic remainder in MSB-first form; the reflected register holds its bit reverse.
  localparam logic [31:0] CRC32_RESIDUE       = 32'hC704_DD7B;
  localparam int          DEFAULT_IFG_NIBBLES = 24;
  localparam int          DEFAULT_PRE_NIBBLES = 15;
  localparam int          FCS_NIBBLES         = 8;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // One nibble of the reflected CRC-32, consumed LSB first like the wire order.
  function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc,
                                                 input logic [3:0]  nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ reflect32(CRC32_POLY);
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/tiny_eth_crc32_nib.sv
// Nibble-serial Ethernet CRC-32 generator with synchronous clear.
// Present only when TINY_ETH_TX_FCS_EN is defined.
`ifdef TINY_ETH_TX_FCS_EN
module tiny_eth_crc32_nib
  import tiny_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [3:0]  nib,
  output logic [31:0] fcs
);

  logic [31:0] crc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc <= CRC32_INIT;
    else if (clear) crc <= CRC32_INIT;
    else if (en)    crc <= crc32_nib_step(crc, nib);
  end

  assign fcs = ~crc;

endmodule
`endif

// File: rtl/tiny_eth_tx_sched.sv
// Round-robin MII transmit scheduler: preamble/SFD, nibble serialisation, IFG.
// Define TINY_ETH_TX_FCS_EN to append a generated CRC-32 FCS to each frame.
module tiny_eth_tx_sched
  import tiny_eth_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int IFG_NIBBLES = DEFAULT_IFG_NIBBLES,
  parameter  int PRE_NIBBLES = DEFAULT_PRE_NIBBLES,
  localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 tx_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           tx_data,
  output logic                 tx_en,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun
);

  localparam int CNT_MAX0 = (IFG_NIBBLES > PRE_NIBBLES) ? IFG_NIBBLES : PRE_NIBBLES;
  localparam int CNT_MAX  = (CNT_MAX0 > FCS_NIBBLES) ? CNT_MAX0 : FCS_NIBBLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  tx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       hold_nib;
  logic             last_hold;
  logic             phase_hi;

  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             ready_sel;
  logic             any_valid;
  logic [GID_W-1:0] next_gid;

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[8*grant_id +: 8];

  // Lowest rotated offset from the last grant wins; the loop runs high to low so it overrides.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    any_valid = 1'b0;
    next_gid  = grant_id;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(grant_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        next_gid  = GID_W'(idx);
      end
    end
  end

  always_comb begin
    ready_sel = 1'b0;
    case (state)
      ST_SFD:  ready_sel = 1'b1;
      ST_DATA: ready_sel = phase_hi & ~last_hold;
      ST_DROP: ready_sel = 1'b1;
      default: ready_sel = 1'b0;
    endcase
    req_ready           = '0;
    req_ready[grant_id] = ready_sel;
  end

`ifdef TINY_ETH_TX_FCS_EN
  logic        crc_clear;
  logic        crc_en;
  logic [3:0]  crc_nib;
  logic [31:0] fcs_word;

  // The CRC advances exactly when a payload nibble is loaded into tx_data.
  always_comb begin
    crc_clear = (state == ST_IDLE);
    crc_en    = 1'b0;
    crc_nib   = sel_data[3:0];
    if (ready_sel && sel_valid && state != ST_DROP) begin
      crc_en = 1'b1;
    end else if (state == ST_DATA && !phase_hi) begin
      crc_en  = 1'b1;
      crc_nib = hold_nib;
    end
  end

  tiny_eth_crc32_nib u_crc (
    .clk   (tx_clk),
    .rst_n (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .nib   (crc_nib),
    .fcs   (fcs_word)
  );
`endif

  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hold_nib   <= '0;
      last_hold  <= 1'b0;
      phase_hi   <= 1'b0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      grant_id   <= GID_W'(NUM_REQ - 1);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= next_gid;
            busy     <= 1'b1;
            tx_en    <= 1'b1;
            tx_data  <= PREAMBLE_NIBBLE;
            cnt      <= CNT_W'(1);
            state    <= ST_PRE;
          end
        end

        ST_PRE: begin
          if (cnt == CNT_W'(PRE_NIBBLES)) begin
            tx_data <= SFD_NIBBLE;
            state   <= ST_SFD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SFD, ST_DATA: begin
          if (state == ST_DATA && !phase_hi) begin
            tx_data  <= hold_nib;
            phase_hi <= 1'b1;
          end else if (state == ST_DATA && last_hold) begin
`ifdef TINY_ETH_TX_FCS_EN
            tx_data <= fcs_word[3:0];
            cnt     <= CNT_W'(1);
            state   <= ST_FCS;
`else
            tx_en      <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b1;
            cnt        <= CNT_W'(1);
            state      <= ST_IFG;
`endif
          end else if (sel_valid) begin
            tx_data   <= sel_data[3:0];
            hold_nib  <= sel_data[7:4];
            last_hold <= sel_last;
            phase_hi  <= 1'b0;
            state     <= ST_DATA;
          end else begin
            // Requester starved the wire mid-frame: abort and flush the rest of its frame.
            tx_en    <= 1'b0;
            tx_data  <= '0;
            underrun <= 1'b1;
            state    <= ST_DROP;
          end
        end

`ifdef TINY_ETH_TX_FCS_EN
        ST_FCS: begin
          if (cnt == CNT_W'(FCS_NIBBLES)) begin
            tx_en      <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b1;
            cnt        <= CNT_W'(1);
            state      <= ST_IFG;
          end else begin
            tx_data <= fcs_word[{cnt[2:0], 2'b00} +: 4];
            cnt     <= cnt + 1'b1;
          end
        end
`endif

        ST_DROP: begin
          if (sel_valid && sel_last) begin
            cnt   <= CNT_W'(1);
            state <= ST_IFG;
          end
        end

        ST_IFG: begin
          if (cnt == CNT_W'(IFG_NIBBLES)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_eth_tx_sched.sv
// Scoreboard bench for tiny_eth_tx_sched: stimulus queues expected nibbles/events,
// an independent monitor pops and compares whatever the DUT puts on the wire.
module tb_tiny_eth_tx_sched;

  localparam int NUM_REQ  = 2;
  localparam int GID_W    = 1;
  localparam int EV_DONE  = 0;
  localparam int EV_UNDER = 1;

  typedef struct {
    logic [3:0]       nib;
    logic [GID_W-1:0] gid;
  } nib_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } item_t;

  logic                 tx_clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3:0]           tx_data;
  logic                 tx_en;
  logic [GID_W-1:0]     grant_id;
  logic                 busy;
  logic                 frame_done;
  logic                 underrun;

  nib_t       exp_q[$];
  int         ev_q[$];
  int         gaps[$];
  item_t      drv_q[NUM_REQ][$];
  int         hs_cnt[NUM_REQ];
  int         gap_cnt[NUM_REQ];
  logic [7:0] fb[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_ignore = 1'b0;

  tiny_eth_tx_sched #(.NUM_REQ(NUM_REQ)) dut (
    .tx_clk     (tx_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

`ifdef TINY_ETH_TX_FCS_EN
  // Byte-wise reference CRC, independent of the nibble-serial hardware form.
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fb[k]) begin
      c = c ^ {24'h0, fb[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  // Queue the frame in fb for requester id; cut>0 starves the wire after byte number cut.
  task automatic push_frame(input int id, input int cut, input bit expect_out);
    int   n_out;
    nib_t e;
    item_t it;
    n_out = (cut > 0) ? cut : fb.size();
    if (expect_out) begin
      e.gid = GID_W'(id);
      for (int k = 0; k < 15; k++) begin
        e.nib = 4'h5;
        exp_q.push_back(e);
      end
      e.nib = 4'hD;
      exp_q.push_back(e);
      for (int k = 0; k < n_out; k++) begin
        e.nib = fb[k][3:0];
        exp_q.push_back(e);
        e.nib = fb[k][7:4];
        exp_q.push_back(e);
      end
`ifdef TINY_ETH_TX_FCS_EN
      if (cut == 0) begin
        logic [31:0] f;
        f = ref_fcs();
        for (int k = 0; k < 8; k++) begin
          e.nib = f[4*k +: 4];
          exp_q.push_back(e);
        end
      end
`endif
      ev_q.push_back((cut > 0) ? EV_UNDER : EV_DONE);
    end
    for (int k = 0; k < fb.size(); k++) begin
      it.data = fb[k];
      it.last = (k == fb.size() - 1);
      it.gap  = (cut > 0 && k == cut) ? 2 : 0;
      drv_q[id].push_back(it);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (!(drv_q[0].size() == 0 && drv_q[1].size() == 0 && !busy &&
                 exp_q.size() == 0) && n < budget);
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Requester models: hold valid/data/last until accepted, optional pre-byte starvation gap.
  initial begin
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hs_cnt[i]  = 0;
      gap_cnt[i] = 0;
    end
    forever begin
      @(posedge tx_clk);
      hs = req_valid & req_ready;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && drv_q[i].size() > 0) begin
          void'(drv_q[i].pop_front());
          hs_cnt[i]++;
          gap_cnt[i] = 0;
        end
        if (drv_q[i].size() > 0 && gap_cnt[i] >= drv_q[i][0].gap) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = drv_q[i][0].data;
          req_last[i]         = drv_q[i][0].last;
        end else begin
          if (drv_q[i].size() > 0) gap_cnt[i]++;
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every transmitted nibble and every status pulse against the queues.
  initial begin
    bit   prev_en;
    bit   seen;
    int   low_run;
    int   ev;
    nib_t e;
    prev_en = 1'b0;
    seen    = 1'b0;
    low_run = 0;
    forever begin
      @(negedge tx_clk);
      if (!rst || mon_ignore) begin
        prev_en = 1'b0;
        seen    = 1'b0;
        low_run = 0;
      end else begin
        if (tx_en) begin
          if (exp_q.size() == 0) begin
            check("nibble_queue", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.nib));
            check("grant_id", 32'(grant_id), 32'(e.gid));
          end
          check("busy_with_tx_en", 32'(busy), 32'd1);
          if (!prev_en && seen) gaps.push_back(low_run);
          seen    = 1'b1;
          low_run = 0;
        end else begin
          low_run++;
        end
        if (frame_done || underrun) begin
          check("event_edge", 32'({tx_en, prev_en}), 32'b01);
          if (ev_q.size() == 0) begin
            check("event_queue", 32'(ev_q.size()), 32'd1);
          end else begin
            ev = ev_q.pop_front();
            check("event_kind", underrun ? EV_UNDER : EV_DONE, 32'(ev));
          end
        end
        prev_en = tx_en;
      end
    end
  end

  initial begin
    int n;
    int h;
    int g;
    bit saw;
    rst = 1'b0;
    repeat (3) @(negedge tx_clk);

    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd1);
    rst = 1'b1;
    @(negedge tx_clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Two-byte frame from requester 0; IFG length observed through busy.
    fb.delete();
    fb.push_back(8'h12);
    fb.push_back(8'h34);
    push_frame(0, 0, 1'b1);
    n   = 0;
    saw = 1'b0;
    while (n < 300) begin
      @(negedge tx_clk);
      n++;
      if (tx_en) saw = 1'b1;
      else if (saw) break;
    end
    check("t1_tx_en_fell", 32'(saw && !tx_en), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge tx_clk);
    end
    check("t1_busy_ifg_cycles", 32'(n), 32'd24);
    wait_idle("t1_idle", 300);
    check("t1_handshakes", 32'(hs_cnt[0]), 32'd2);

    // Single-byte frame from requester 1.
    h = hs_cnt[1];
    fb.delete();
    fb.push_back(8'hA5);
    push_frame(1, 0, 1'b1);
    wait_idle("t4_idle", 300);
    check("t4_handshakes", 32'(hs_cnt[1] - h), 32'd1);

    // Both requesters continuously busy with 3-byte frames: 0,1,0,1.
    fb.delete();
    fb.push_back(8'h01); fb.push_back(8'h02); fb.push_back(8'h03);
    push_frame(0, 0, 1'b1);
    fb.delete();
    fb.push_back(8'h11); fb.push_back(8'h12); fb.push_back(8'h13);
    push_frame(1, 0, 1'b1);
    fb.delete();
    fb.push_back(8'h04); fb.push_back(8'h05); fb.push_back(8'h06);
    push_frame(0, 0, 1'b1);
    fb.delete();
    fb.push_back(8'h14); fb.push_back(8'h15); fb.push_back(8'h16);
    push_frame(1, 0, 1'b1);
    wait_idle("t2_idle", 1000);
    g = gaps.size();
    check("t2_gap_count", 32'(g >= 3), 32'd1);
    if (g >= 3) begin
      for (int j = 0; j < 3; j++) check("t2_gap_len", 32'(gaps[g-3+j]), 32'd25);
    end

    // Requester 1 starves after its 2nd byte; the rest of the frame is flushed.
    h = hs_cnt[1];
    fb.delete();
    for (int k = 0; k < 5; k++) fb.push_back(8'h21 + 8'(k));
    push_frame(1, 2, 1'b1);
    wait_idle("t3_idle", 300);
    check("t3_handshakes", 32'(hs_cnt[1] - h), 32'd5);

    // Reset in the middle of a payload.
    mon_ignore = 1'b1;
    h = hs_cnt[0];
    fb.delete();
    for (int k = 0; k < 8; k++) fb.push_back(8'h40 + 8'(k));
    push_frame(0, 0, 1'b0);
    n = 0;
    while (hs_cnt[0] - h < 3 && n < 300) begin
      @(negedge tx_clk);
      n++;
    end
    check("t5_mid_payload", 32'(hs_cnt[0] - h >= 3), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_tx_en", 32'(tx_en), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_grant", 32'(grant_id), 32'd1);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) drv_q[i].delete();
    req_valid = '0;
    req_last  = '0;
    exp_q.delete();
    ev_q.delete();
    @(negedge tx_clk);
    rst = 1'b1;
    mon_ignore = 1'b0;
    fb.delete();
    fb.push_back(8'h3C);
    fb.push_back(8'h7E);
    push_frame(0, 0, 1'b1);
    fb.delete();
    fb.push_back(8'h81);
    push_frame(1, 0, 1'b1);
    wait_idle("t5_idle", 600);

`ifdef TINY_ETH_TX_FCS_EN
    fb.delete();
    for (int k = 0; k < 60; k++) fb.push_back(8'h00);
    push_frame(0, 0, 1'b1);
    wait_idle("fcs_idle", 1000);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
